// File: rtl/dec_char_formatter.sv
// dec_char_formatter: converts an unsigned binary value to decimal ASCII text,
// streamed one character per valid/ready beat with no leading zeros.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake; in_data is the WIDTH-bit value
//   out_valid/out_ready output handshake; out_data is the ASCII character
//   out_last          set on the final (units) digit of each value
//
// Parameters:
//   WIDTH   bit width of in_data
//   DIGITS  BCD digit count, at least ceil(WIDTH*log10(2))
//
// Build option:
//   DEC_FMT_PREFIX_EN  when defined, each value is preceded by "Value = "
module dec_char_formatter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last
);

    localparam int BW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_PREFIX = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Holds in_ready low until the first clock after reset release.
    logic             r_alive;

    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;

    logic [BW-1:0]    w_bcd_adj;
    logic [BW-1:0]    w_bcd_nxt;
    logic [IW-1:0]    w_msd;
    logic [3:0]       w_digit;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_conv_done;
    logic             w_idx_zero;

`ifdef DEC_FMT_PREFIX_EN
    logic [2:0]       r_pidx;
    logic [7:0]       w_pchar;
`endif

    assign w_in_hs     = in_valid && in_ready;
    assign w_out_hs    = out_valid && out_ready;
    assign w_conv_done = (r_state == S_CONV) && (r_cnt == CNT_LAST);
    assign w_idx_zero  = (r_idx == '0);

    // One double-dabble step: add 3 to every nibble >= 5, then shift the
    // next input bit (MSB first) into the BCD accumulator.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_nxt = {w_bcd_adj[BW-2:0], r_shift[WIDTH-1]};
    end

    // Highest non-zero digit of the finished result; digit 0 when all zero,
    // so a zero value still prints a single '0'.
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd_nxt[4*i +: 4] != 4'd0) begin
                w_msd = IW'(i);
            end
        end
    end

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_digit = r_bcd[4*i +: 4];
            end
        end
    end

`ifdef DEC_FMT_PREFIX_EN
    always_comb begin
        unique case (r_pidx)
            3'd0:    w_pchar = 8'h56;
            3'd1:    w_pchar = 8'h61;
            3'd2:    w_pchar = 8'h6C;
            3'd3:    w_pchar = 8'h75;
            3'd4:    w_pchar = 8'h65;
            3'd5:    w_pchar = 8'h20;
            3'd6:    w_pchar = 8'h3D;
            default: w_pchar = 8'h20;
        endcase
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (w_conv_done) begin
`ifdef DEC_FMT_PREFIX_EN
                    w_state_nxt = S_PREFIX;
`else
                    w_state_nxt = S_EMIT;
`endif
                end
            end
`ifdef DEC_FMT_PREFIX_EN
            S_PREFIX: begin
                if (w_out_hs && (r_pidx == 3'd7)) begin
                    w_state_nxt = S_EMIT;
                end
            end
`endif
            S_EMIT: begin
                if (w_out_hs && w_idx_zero) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from state only so they clear with reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = r_alive;
            end
`ifdef DEC_FMT_PREFIX_EN
            S_PREFIX: begin
                out_valid = 1'b1;
                out_data  = w_pchar;
            end
`endif
            S_EMIT: begin
                out_valid = 1'b1;
                out_data  = 8'h30 + {4'h0, w_digit};
                out_last  = w_idx_zero;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    // Conversion datapath and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else if (w_in_hs) begin
            r_shift <= in_data;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_CONV) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_bcd   <= w_bcd_nxt;
            r_cnt   <= r_cnt + 1'b1;
            if (w_conv_done) begin
                r_idx <= w_msd;
            end
        end else if ((r_state == S_EMIT) && w_out_hs && !w_idx_zero) begin
            r_idx <= r_idx - 1'b1;
        end
    end

`ifdef DEC_FMT_PREFIX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pidx <= '0;
        end else if (w_conv_done) begin
            r_pidx <= '0;
        end else if ((r_state == S_PREFIX) && w_out_hs) begin
            r_pidx <= r_pidx + 1'b1;
        end
    end
`endif

endmodule
